sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM read/write/finished port among N_REQ cores: record, playback, mixer, loader.
- Uses round-robin arbitration. Exactly one transaction is in flight at a time.
- Latches the winner's command and routes readdata and the finished pulse back to that requester only.
- Sits between the audio cores and the SDRAM controller wrapper.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- ADDR_W, 23, SDRAM word address width.
- DATA_W, 32, SDRAM data width.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- req_read  in  [N_REQ]  per-requester read request, held until finished.
- req_write  in  [N_REQ]  per-requester write request, held until finished.
- req_addr  in  [N_REQ][ADDR_W]  per-requester address.
- req_writedata  in  [N_REQ][DATA_W]  per-requester write data.
- req_readdata  out  DATA_W  broadcast read data. Valid for the granted requester on its finished cycle.
- req_finished  out  [N_REQ]  one-cycle completion pulse to the granted requester only.
- sdram_read  out  1  read command to SDRAM controller.
- sdram_write  out  1  write command to SDRAM controller.
- sdram_addr  out  ADDR_W  latched address.
- sdram_writedata  out  DATA_W  latched write data.
- sdram_readdata  in  DATA_W  data from SDRAM.
- sdram_finished  in  1  transaction-complete pulse from SDRAM.
- grant_id  out  $clog2(N_REQ)  index of current or last grant.
- busy  out  1  high while in BUSY.
- timeout_err  out  1  sticky watchdog flag. Tied 0 without the macro.

Behaviour:
- Reset values:
  - state = IDLE.
  - sdram_read, sdram_write, sdram_addr, sdram_writedata = 0.
  - req_finished = 0, busy = 0, timeout_err = 0.
  - grant_id = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 wins first.
- A requester is active when req_read | req_write.
- IDLE:
  - Search active requesters starting at (last+1) mod N_REQ, wrapping.
  - On the first hit k, register at the next edge: grant_id = k, last = k, addr/writedata = req_*[k].
  - Also register the command: write if req_write[k], else read. Write wins if both are asserted.
  - Go to BUSY.
  - No active requester: stay in IDLE with commands at 0.
- BUSY:
  - sdram_read/sdram_write are driven from the latched command. sdram_addr/sdram_writedata come from latches.
  - Later changes on req_* are ignored.
  - When sdram_finished = 1: req_finished[grant_id] = 1 combinationally in that same cycle, and req_readdata = sdram_readdata.
  - Commands clear at the next edge and the block returns to IDLE.
- Latency:
  - Request at edge t gives a command at t+1.
  - The finished pulse is passed through in the same cycle as sdram_finished.
  - Minimum 1 idle cycle between back-to-back grants.
- Fairness: a requester that re-asserts right after finishing gets the grant again only if no other requester is active.
- Requester withdraws while granted: the transaction still completes and the finished pulse is still delivered.
- sdram_finished while in IDLE: ignored, and no req_finished.
- N_REQ arithmetic: wrap is modulo N_REQ. Non-power-of-2 values must wrap correctly.
- Reset mid-BUSY: commands drop immediately. The pointer returns to N_REQ-1 and the in-flight transaction is abandoned.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With it defined:
  - A cycle counter runs in BUSY.
  - If TIMEOUT_CYCLES elapse without sdram_finished: the arbiter pulses req_finished[grant_id] with readdata = 0, sets timeout_err (sticky until reset), and returns to IDLE.
- Without it: no counter, and BUSY waits indefinitely.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, BUSY}.
  - cmd_t enum {CMD_READ, CMD_WRITE}.
  - Default width constants ADDR_W/DATA_W.
- Sub-module rr_pick:
  - Combinational round-robin priority search.
  - Takes an active vector and last pointer; returns the hit flag and index.

Test Plan:
- Single write: req_write[0] = 1, addr 0x000010, data 0xDEADBEEF. Expected: sdram_write = 1 next cycle with those values. sdram_finished 3 cycles later gives req_finished[0] = 1 for exactly 1 cycle, then back to IDLE.
- Round-robin: reqs 0, 1, 2 all hold read requests. Expected grant order 0, 1, 2, 0. Each sees the finished pulse only on its own bit.
- Read data routing: req_read[2] at addr 0x7FFFFF, sdram_readdata = 0x12345678 with finished. Expected: req_readdata = 0x12345678 and only req_finished[2] is high.
- Stable latch: after grant to requester 1, change req_addr[1] to 0x5. Expected: sdram_addr stays at the original value until finished.
- Reset mid-transaction: assert i_rst during BUSY. Expected: commands drop to 0 immediately. After release, requester 0 is granted first.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16, no sdram_finished. Expected: req_finished pulses at cycle 16 and timeout_err = 1 stays high.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
package sdram_arb_pkg;

  // Arbiter FSM: IDLE searches for a requester, BUSY owns the SDRAM port.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Latched command of the granted requester.
  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first active index after i_last, wrapping
// modulo N (works for non-power-of-2 N).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_active,
  input  logic [IW-1:0] i_last,
  output logic          o_hit,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Walk candidates last+1 .. last+N; the first active one wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = IW'((int'(i_last) + i) % N);
      if (!o_hit && i_active[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM read/write/finished port among N_REQ
// requesters. One transaction in flight; the winner's command is latched and the
// finished pulse / read data are routed back to it only.
//
// Handshake: a requester raises req_read and/or req_write (write wins if both)
// and holds it with stable address/data until it sees its req_finished bit for
// one cycle; changes while granted are ignored because the command is latched.
// sdram_read/sdram_write stay high until sdram_finished is seen in BUSY.
//
// Optional macro ARB_TIMEOUT_EN: a BUSY watchdog that force-completes the
// transaction after TIMEOUT_CYCLES with zero read data and sets sticky
// timeout_err. Without it BUSY waits indefinitely and timeout_err is 0.
// The busy output is the FSM state view (1 = BUSY).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_REQ-1:0]               req_read,
  input  logic [N_REQ-1:0]               req_write,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]              req_readdata,
  output logic [N_REQ-1:0]               req_finished,
  output logic                           sdram_read,
  output logic                           sdram_write,
  output logic [ADDR_W-1:0]              sdram_addr,
  output logic [DATA_W-1:0]              sdram_writedata,
  input  logic [DATA_W-1:0]              sdram_readdata,
  input  logic                           sdram_finished,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IW = $clog2(N_REQ);

  state_t            r_state;
  state_t            w_state_nxt;
  cmd_t              r_cmd;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [N_REQ-1:0]  w_active;
  logic              w_hit;
  logic [IW-1:0]     w_pick;
  logic              w_load;
  logic              w_done;
  logic              w_timeout_fire;

  assign w_active = req_read | req_write;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_active (w_active),
    .i_last   (r_last),
    .o_hit    (w_hit),
    .o_idx    (w_pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] r_tcnt;
  logic           r_timeout;

  // Count BUSY cycles; cleared in IDLE so each grant starts from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_tcnt <= '0;
      end else if (!w_done) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_timeout_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle if the SDRAM has not finished.
  assign w_timeout_fire = (r_state == BUSY) && !sdram_finished &&
                          (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign timeout_err    = r_timeout;
  assign req_readdata   = w_timeout_fire ? '0 : sdram_readdata;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout_fire   = 1'b0;
  assign timeout_err      = 1'b0;
  assign req_readdata     = sdram_readdata;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant on any active requester, release on SDRAM completion.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (sdram_finished || w_timeout_fire) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Latch the winner's command, address and data; the pointer restarts at
  // N_REQ-1 so requester 0 is served first after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last  <= IW'(N_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cmd   <= CMD_READ;
    end else if (w_load) begin
      r_last  <= w_pick;
      r_grant <= w_pick;
      r_addr  <= req_addr[w_pick];
      r_wdata <= req_writedata[w_pick];
      r_cmd   <= req_write[w_pick] ? CMD_WRITE : CMD_READ;
    end
  end

  assign busy            = (r_state == BUSY);
  assign sdram_read      = busy && (r_cmd == CMD_READ);
  assign sdram_write     = busy && (r_cmd == CMD_WRITE);
  assign sdram_addr      = r_addr;
  assign sdram_writedata = r_wdata;
  assign grant_id        = r_grant;
  assign req_finished    = w_done ? (N_REQ'(1) << r_grant) : '0;

endmodule
